// File: rtl/axis_pack_arbiter_if.sv
// AXI-Stream bundle with LANES side-by-side channels (LANES=NREQ on the requester side, 1 on the packer side).
interface axis_pack_arbiter_if #(
    parameter int N     = 5,
    parameter int LANES = 1
);
    localparam int NB = N * 8;

    logic [LANES*NB-1:0] tdata;
    logic [LANES*N-1:0]  tkeep;
    logic [LANES-1:0]    tlast;
    logic [LANES-1:0]    tvalid;
    logic [LANES-1:0]    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_pack_arbiter.sv
// Packet-locked round-robin arbiter sharing one gearbox packer input through a single register slice.
// Optional macro PACK_ARB_PRIO_EN: requester 0 wins every arbitration it bids for; the rest round-robin.
module axis_pack_arbiter #(
    parameter int N    = 5,
    parameter int NB   = N * 8,
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_pack_arbiter_if.slave  s,
    axis_pack_arbiter_if.master m,
    output logic [GW-1:0]       grant_id,
    output logic                busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   last_reg, last_next;

    logic [NB-1:0]   m_data_reg;
    logic [N-1:0]    m_keep_reg;
    logic            m_last_reg;
    logic            m_valid_reg;

    logic [NB-1:0]   lane_data [NREQ];
    logic [N-1:0]    lane_keep [NREQ];

    logic [NB-1:0]   sel_data;
    logic [N-1:0]    sel_keep;
    logic            sel_last;
    logic            sel_valid;
    logic            slot_free;
    logic            accept;
    logic            forward;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_data[gi] = s.tdata[gi*NB +: NB];
            assign lane_keep[gi] = s.tkeep[gi*N +: N];
            assign s.tready[gi]  = (state_reg == BUSY) && (grant_reg == GW'(gi)) && slot_free;
        end
    endgenerate

    assign sel_data  = lane_data[grant_reg];
    assign sel_keep  = lane_keep[grant_reg];
    assign sel_last  = s.tlast[grant_reg];
    assign sel_valid = s.tvalid[grant_reg];

    assign slot_free = ~m_valid_reg | m.tready[0];
    assign accept    = (state_reg == BUSY) && sel_valid && slot_free;
    // Empty non-final beats are swallowed; an empty final beat still carries tlast.
    assign forward   = accept && ((sel_keep != '0) || sel_last);

    // First bidder after 'from' in circular order.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [GW-1:0] from);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
`ifdef PACK_ARB_PRIO_EN
        if (req[0]) found = 1'b1;
`endif
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(from) + off) % NREQ;
`ifdef PACK_ARB_PRIO_EN
            if (!found && idx != 0 && req[idx]) begin
`else
            if (!found && req[idx]) begin
`endif
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (|s.tvalid) begin
                    grant_next = rr_pick(s.tvalid, last_reg);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_next = IDLE;
`ifdef PACK_ARB_PRIO_EN
                    if (grant_reg != '0) last_next = grant_reg;
`else
                    last_next = grant_reg;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= GW'(NREQ - 1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
            m_last_reg  <= 1'b0;
            m_valid_reg <= 1'b0;
        end else if (forward) begin
            m_data_reg  <= sel_data;
            m_keep_reg  <= sel_keep;
            m_last_reg  <= sel_last;
            m_valid_reg <= 1'b1;
        end else if (m.tready[0]) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m.tdata  = m_data_reg;
    assign m.tkeep  = m_keep_reg;
    assign m.tlast  = m_last_reg;
    assign m.tvalid = m_valid_reg;

    assign grant_id = grant_reg;
    assign busy     = (state_reg == BUSY);

endmodule

// File: doc/axis_pack_arbiter.md
Name: axis_pack_arbiter

Overview:
- Packet-level round-robin arbiter that shares one gearbox_packing input among NREQ AXI-Stream requesters.
- Grant locks to one requester from its first beat through the beat carrying tlast, so packets never interleave at the packer.
- Output goes through a single registered slice. Its m_* side connects directly to the packer's in_* side.

Parameters:
- N, 5, bytes per beat; must equal packer n.
- NB, N*8, data width in bits.
- NREQ, 4, number of requesters; must be >= 2.
- GW, $clog2(NREQ), grant index width.

Ports:
- aclk  in  1  clock; all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_tdata  in  NREQ*NB  requester data; requester i at bits [i*NB +: NB].
- s_tkeep  in  NREQ*N  requester byte enables; requester i at bits [i*N +: N].
- s_tlast  in  NREQ  end-of-packet, one bit per requester.
- s_tvalid  in  NREQ  beat valid, one bit per requester.
- s_tready  out  NREQ  beat accepted, one bit per requester.
- m_tdata  out  NB  to packer in_tdata.
- m_tkeep  out  N  to packer in_tkeep.
- m_tlast  out  1  end-of-packet.
- m_tvalid  out  1  to packer in_tvalid.
- m_tready  in  1  from packer in_tready.
- grant_id  out  GW  requester currently granted; holds last value when idle.
- busy  out  1  high in state BUSY.

Behaviour:
- Reset (async assert, sync-released):
  - State IDLE.
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - grant_id=0, busy=0, s_tready=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- Output slice:
  - slot_free = ~m_tvalid | m_tready.
  - On a forwarded acceptance, the register loads the beat and sets m_tvalid=1.
  - Otherwise, when m_tvalid & m_tready, m_tvalid clears.
  - m_* holds stable while m_tvalid & ~m_tready (AXI rule).
- State IDLE:
  - s_tready all 0.
  - If any s_tvalid is high at a rising edge: grant_id <= first requester with tvalid=1, searching last+1, last+2, ... mod NREQ. State <= BUSY.
- State BUSY:
  - s_tready[grant_id] = slot_free; all other s_tready = 0. Strictly one-hot or zero.
  - Acceptance = s_tvalid[g] & s_tready[g].
  - Accepted beat with tlast=1: forwarded, then state <= IDLE, last <= grant_id.
- Latency:
  - Requester valid seen at edge k → grant at edge k → first beat accepted at edge k+1 → m_tvalid=1 after edge k+1.
  - One idle cycle between consecutive packets (re-arbitration).
  - Within a packet: full throughput, one beat per cycle while m_tready=1.
- Null beats:
  - Accepted beat with tkeep==0 and tlast=0 is consumed (s_tready pulses) but not forwarded; m_tvalid is unaffected.
  - tkeep==0 with tlast=1 is forwarded, so tlast is not lost.
- Boundary conditions:
  - Granted requester drops tvalid mid-packet: grant is held, bubbles pass, no other requester is served.
  - Single-beat packet (tlast on first beat): handled, returns to IDLE.
  - Requesters not granted wait indefinitely; their s_* inputs are ignored.
  - aresetn asserted mid-packet: immediate return to reset values; the partial packet is discarded (downstream packer is reset by the same aresetn).
  - m_tready held low: upstream stalls; no beat is lost or duplicated.

Optional Feature:
- Macro: PACK_ARB_PRIO_EN.
- Defined:
  - Requester 0 has strict priority at every arbitration point (IDLE) whenever s_tvalid[0]=1.
  - Requesters 1..NREQ-1 round-robin among themselves.
  - last is not updated when requester 0 is granted.
  - Mid-packet locking is unchanged; requester 0 never preempts a packet in progress.
- Undefined: plain round-robin across all NREQ as above.

Test Plan:
- Reset, then requester 2 sends 3 beats (tkeep=5'h1F, last on beat 3), m_tready=1 → grant_id=2; m_tvalid asserts 2 edges after s_tvalid; 3 consecutive beats; busy drops the cycle after the tlast acceptance.
- All 4 requesters continuously send 2-beat packets → grant order 0,1,2,3,0; exactly one idle cycle between packets; no interleaving.
- Requester 1 mid-packet, m_tready toggles 1,0,0,1 → m_tdata/m_tkeep stable during stall; s_tready[1]=0 while slot is full; beat count at output = 4.
- Requester 0 sends beats with tkeep=0,0x1F,0 (last on the third) → output carries 2 beats (0x1F, then tkeep=0 with tlast=1).
- aresetn pulsed low on beat 2 of a 4-beat packet → all outputs 0 immediately; after release requester 0 is granted first.
- With PACK_ARB_PRIO_EN, requesters 0 and 3 always valid → grants 0,0,0…; requester 0 idle for one arbitration → 3 granted; without the macro → 0,3 alternate.
